// File: rtl/uart_pkg.sv
// Shared UART definitions: FCR trigger-level encodings and thresholds, LSR bit
// positions and IIR interrupt identification codes.
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_4  = 2'd1,
    TRIG_8  = 2'd2,
    TRIG_14 = 2'd3
  } trig_level_e;

  localparam logic [4:0] TRIG_THRESH_1  = 5'd1;
  localparam logic [4:0] TRIG_THRESH_4  = 5'd4;
  localparam logic [4:0] TRIG_THRESH_8  = 5'd8;
  localparam logic [4:0] TRIG_THRESH_14 = 5'd14;

  localparam int LSR_DR_BIT   = 0;
  localparam int LSR_OE_BIT   = 1;
  localparam int LSR_THRE_BIT = 5;
  localparam int LSR_TEMT_BIT = 6;

  localparam logic [3:0] IIR_ID_RDA = 4'h4;
  localparam logic [3:0] IIR_ID_CTO = 4'hC;

  function automatic logic [4:0] trig_threshold(input logic [1:0] lvl);
    logic [4:0] thr;
    case (trig_level_e'(lvl))
      TRIG_1:  thr = TRIG_THRESH_1;
      TRIG_4:  thr = TRIG_THRESH_4;
      TRIG_8:  thr = TRIG_THRESH_8;
      default: thr = TRIG_THRESH_14;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 receive FIFO storage: synchronous write port, combinational read
// port so the head byte falls through to rd_data without a read cycle.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO with sticky overrun and trigger-level status.
// Define UART_RX_TIMEOUT_EN to build the character-timeout timer and timeout_irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 360
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clr_overrun,
  input  logic [1:0]               trig_level,
  output logic [7:0]               rd_data,
  output logic                     data_ready,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     trig_irq,
  output logic                     timeout_irq
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overrun_reg, overrun_next;

  logic full, empty;
  logic do_push, do_pop, overrun_evt, mem_wr_en;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A pop on a full FIFO frees the slot the coincident push lands in.
  assign do_pop      = rd_en && !empty;
  assign do_push     = rx_rdy && (!full || do_pop);
  assign overrun_evt = rx_rdy && full && !do_pop;
  assign mem_wr_en   = do_push && !flush && !reset;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    if (flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      overrun_next = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_next = count_reg - CNT_W'(1);
      end
      // A fresh overrun outranks a simultaneous LSR-read clear.
      if (overrun_evt) begin
        overrun_next = 1'b1;
      end else if (clr_overrun) begin
        overrun_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  assign count      = count_reg;
  assign overrun    = overrun_reg;
  assign data_ready = !empty;
  assign trig_irq   = (int'(count_reg) >= int'(trig_threshold(trig_level)));

`ifdef UART_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_reg, timer_next;

  // Any FIFO activity restarts the idle measurement; it then saturates.
  always_comb begin
    timer_next = timer_reg;
    if (flush || do_push || do_pop || empty) begin
      timer_next = '0;
    end else if (timer_reg != TMR_MAX) begin
      timer_next = timer_reg + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end

  assign timeout_irq = (timer_reg == TMR_MAX) && !empty;
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
// Timeout expectations follow UART_RX_TIMEOUT_EN.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       flush;
  logic       clr_overrun;
  logic [1:0] trig_level;
  logic [7:0] rd_data;
  logic       data_ready;
  logic       overrun;
  logic [4:0] count;
  logic       trig_irq;
  logic       timeout_irq;

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rd_en       (rd_en),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .trig_level  (trig_level),
    .rd_data     (rd_data),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .count       (count),
    .trig_irq    (trig_irq),
    .timeout_irq (timeout_irq)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, sticky flag, and the edge of the last accepted activity.
  logic [7:0] q[$];
  logic       m_ovr;
  int         cyc;
  int         last_act;
  int         checks;
  int         errors;

  function automatic int thresh(input logic [1:0] lvl);
    int tbl [4] = '{1, 4, 8, 14};
    return tbl[lvl];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_to;
`ifdef UART_RX_TIMEOUT_EN
    exp_to = (q.size() != 0) && ((cyc - last_act) >= TMO);
`else
    exp_to = 1'b0;
`endif
    check("count", 32'(count), 32'(q.size()));
    check("data_ready", 32'(data_ready), 32'(q.size() != 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("trig_irq", 32'(trig_irq), 32'(q.size() >= thresh(trig_level)));
    check("timeout_irq", 32'(timeout_irq), 32'(exp_to));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  task automatic cycle(input logic rx, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr, input logic rst);
    int  sz;
    logic popped;
    rx_rdy = rx; rx_data = d; rd_en = rd; flush = fl; clr_overrun = clr; reset = rst;
    @(posedge clk);
    cyc++;
    sz = q.size();
    if (rst) begin
      q.delete(); m_ovr = 1'b0; last_act = cyc;
    end else if (fl) begin
      q.delete(); m_ovr = 1'b0; last_act = cyc;
    end else begin
      popped = rd && (sz != 0);
      if (popped) begin
        void'(q.pop_front());
        last_act = cyc;
      end
      if (rx) begin
        if (q.size() < DEPTH) begin
          q.push_back(d);
          last_act = cyc;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (clr) begin
        m_ovr = 1'b0;
      end
      if (rx && q.size() == DEPTH && sz == DEPTH && !popped) m_ovr = 1'b1;
      else if (clr && !(rx && sz == DEPTH && !popped)) m_ovr = 1'b0;
    end
    #1;
    rx_rdy = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0; reset = 1'b0;
    if (rx || rd || fl || rst)
      $display("cyc %0d push=%0b data=%02h pop=%0b flush=%0b reset=%0b -> count=%0d rd_data=%02h ovr=%0b",
               cyc, rx, d, rd, fl, rst, count, rd_data, overrun);
    check_all();
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_flush();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int rise;
    int exp_rise;
    logic [7:0] b;
    checks = 0; errors = 0; cyc = 0; last_act = 0; m_ovr = 1'b0;
    rx_rdy = 0; rx_data = 0; rd_en = 0; flush = 0; clr_overrun = 0; trig_level = 2'd0;
    reset = 1'b1;
`ifdef UART_RX_TIMEOUT_EN
    exp_rise = TMO;
`else
    exp_rise = 0;
`endif

    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_dr", 32'(data_ready), 32'd0);

    // Basic ordering
    push(8'h41); push(8'h42); push(8'h43);
    check("t1_count", 32'(count), 32'd3);
    check("t1_head", 32'(rd_data), 32'h41);
    check("t1_pop0", 32'(rd_data), 32'h41); pop();
    check("t1_pop1", 32'(rd_data), 32'h42); pop();
    check("t1_pop2", 32'(rd_data), 32'h43); pop();
    check("t1_dr_empty", 32'(data_ready), 32'd0);

    // Overrun on a full FIFO
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", 32'(rd_data), 32'(i));
      pop();
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_clr", 32'(overrun), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_ovr", 32'(overrun), 32'd0);
    check("t3_count", 32'(count), 32'd16);
    for (int i = 0; i < 15; i++) pop();
    check("t3_last", 32'(rd_data), 32'h55);
    pop();

    // Trigger levels
    do_flush();
    trig_level = 2'd2;
    for (int i = 0; i < 7; i++) push(8'(i));
    check("t4_l2_at7", 32'(trig_irq), 32'd0);
    push(8'h07);
    check("t4_l2_at8", 32'(trig_irq), 32'd1);
    trig_level = 2'd3; #1;
    check("t4_l3_at8", 32'(trig_irq), 32'd0);
    for (int i = 0; i < 5; i++) push(8'(i));
    check("t4_l3_at13", 32'(trig_irq), 32'd0);
    push(8'h0D);
    check("t4_l3_at14", 32'(trig_irq), 32'd1);
    trig_level = 2'd0;

    // Character timeout, measured in edges after the accepting edge
    do_flush();
    push(8'hC1); push(8'hC2);
    rise = 0;
    for (int k = 1; k <= TMO + 10; k++) begin
      idle();
      if (timeout_irq && rise == 0) rise = k;
    end
    check("t5_rise", 32'(rise), 32'(exp_rise));
    pop();
    check("t5_pop_clr", 32'(timeout_irq), 32'd0);
    rise = 0;
    for (int k = 1; k <= TMO + 10; k++) begin
      idle();
      if (timeout_irq && rise == 0) rise = k;
    end
    check("t5_rerise", 32'(rise), 32'(exp_rise));

    // Flush beats a coincident push
    do_flush();
    for (int i = 0; i < 5; i++) push(8'(i + 8'h20));
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_ovr", 32'(overrun), 32'd0);
    push(8'h10);
    check("t6_head", 32'(rd_data), 32'h10);
    check("t6_count1", 32'(count), 32'd1);

    // Reset mid-operation ignores a coincident strobe
    push(8'h11);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t7_count", 32'(count), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ((n % 32) == 0) trig_level = 2'($urandom_range(0, 3));
      if ((n / 300) % 2 == 1 && (n % 300) > 200) begin
        idle();
      end else begin
        b = 8'($urandom_range(0, 255));
        cycle(($urandom_range(0, 1) == 1), b, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
